// File: rtl/sram_controller_if.sv
// Memory-stage side of the SRAM bridge: request, store data, load data and stall.
// The memory stage is the master; the SRAM controller is the slave.
interface sram_controller_if;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;

    modport master (
        output wr_en,
        output rd_en,
        output address,
        output write_data,
        input  read_data,
        input  ready
    );

    modport slave (
        input  wr_en,
        input  rd_en,
        input  address,
        input  write_data,
        output read_data,
        output ready
    );
endinterface

// File: rtl/sram_controller.sv
// Splits each 32-bit load/store into two 16-bit accesses to an asynchronous SRAM,
// stalling the pipeline through ready until the second half has completed.
module sram_controller #(
    parameter int          ACCESS_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR     = 32'd1024
) (
    input  logic               clk,
    input  logic               rst,
    sram_controller_if.slave   mem,
    output logic [17:0]        sram_addr,
    output logic [15:0]        sram_dq_out,
    output logic               sram_dq_oe,
    input  logic [15:0]        sram_dq_in,
    output logic               sram_we_n,
    output logic               sram_oe_n
);

    localparam int CW = (ACCESS_CYCLES > 2) ? $clog2(ACCESS_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LO   = 2'd1,
        S_HI   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t         state_reg;
    state_t         state_next;
    logic [CW-1:0]  cnt_reg;
    logic           op_wr_reg;
    logic [16:0]    word_idx_reg;
    logic [15:0]    data_hi_reg;
    logic [31:0]    read_data_reg;
    logic [17:0]    sram_addr_reg;
    logic [15:0]    dq_out_reg;

    logic [31:0]    off;
    logic           req;
    logic           last_cycle;
    logic           ready_comb;
    logic           unused_off_bits;

    // Offset arithmetic wraps mod 2^32; only the half-word index bits survive.
    assign off             = mem.address - BASE_ADDR;
    assign unused_off_bits = ^{off[31:19], off[1:0]};
    assign req             = mem.wr_en | mem.rd_en;
    assign last_cycle      = (cnt_reg == CW'(ACCESS_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (req)        state_next = S_LO;
            S_LO:    if (last_cycle) state_next = S_HI;
            S_HI:    if (last_cycle) state_next = S_DONE;
            S_DONE:                  state_next = S_IDLE;
            default:                 state_next = S_IDLE;
        endcase
    end

    always_comb begin
        ready_comb = 1'b0;
        sram_we_n  = 1'b1;
        sram_oe_n  = 1'b1;
        sram_dq_oe = 1'b0;
        case (state_reg)
            S_IDLE: ready_comb = ~req;
            S_LO, S_HI: begin
                if (op_wr_reg) begin
                    sram_dq_oe = 1'b1;
                    // Last cycle of each phase releases the strobe so data holds past WE rising.
                    sram_we_n  = last_cycle;
                end else begin
                    sram_oe_n  = 1'b0;
                end
            end
            S_DONE: ready_comb = 1'b1;
            default: ready_comb = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (state_next != state_reg) begin
            cnt_reg <= '0;
        end else if (state_reg == S_LO || state_reg == S_HI) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_wr_reg     <= 1'b0;
            word_idx_reg  <= '0;
            data_hi_reg   <= '0;
            read_data_reg <= '0;
            sram_addr_reg <= '0;
            dq_out_reg    <= '0;
        end else begin
            if (state_reg == S_IDLE && req) begin
                op_wr_reg     <= mem.wr_en;
                word_idx_reg  <= off[18:2];
                data_hi_reg   <= mem.write_data[31:16];
                sram_addr_reg <= {off[18:2], 1'b0};
                dq_out_reg    <= mem.write_data[15:0];
            end
            if (state_reg == S_LO && last_cycle) begin
                sram_addr_reg <= {word_idx_reg, 1'b1};
                dq_out_reg    <= data_hi_reg;
                if (!op_wr_reg) begin
                    read_data_reg[15:0] <= sram_dq_in;
                end
            end
            if (state_reg == S_HI && last_cycle && !op_wr_reg) begin
                read_data_reg[31:16] <= sram_dq_in;
            end
        end
    end

    assign sram_addr     = sram_addr_reg;
    assign sram_dq_out   = dq_out_reg;
    assign mem.read_data = read_data_reg;
    assign mem.ready     = ready_comb;

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: SRAM array model, per-cycle reference model of the
// transaction timing, directed test-plan cases and randomized traffic.
module tb_sram_controller;

    localparam int          AC     = 2;
    localparam logic [31:0] BASE   = 32'd1024;
    localparam int          DONE_K = 2 * AC + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sram_controller_if mem_if ();

    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic [15:0] sram_dq_in;
    logic [15:0] junk = 16'h0;
    logic        sram_dq_oe;
    logic        sram_we_n;
    logic        sram_oe_n;

    sram_controller #(.ACCESS_CYCLES(AC), .BASE_ADDR(BASE)) dut (
        .clk         (clk),
        .rst         (rst),
        .mem         (mem_if),
        .sram_addr   (sram_addr),
        .sram_dq_out (sram_dq_out),
        .sram_dq_oe  (sram_dq_oe),
        .sram_dq_in  (sram_dq_in),
        .sram_we_n   (sram_we_n),
        .sram_oe_n   (sram_oe_n)
    );

    // External SRAM chip model: 256K x 16
    logic [15:0] sram [0:262143];
    assign sram_dq_in = sram_oe_n ? junk : sram[sram_addr];
    always @(negedge clk) if (!sram_we_n && sram_dq_oe) sram[sram_addr] <= sram_dq_out;
    always @(posedge clk) junk <= 16'($urandom);

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %h, required %h", nm, cyc, act, exp);
        end
    endtask

    // Reference model: transaction position k counts cycles since acceptance.
    bit          chk_en = 0;
    bit          busy = 0;
    int          k = 0;
    bit          m_wr = 0;
    logic [16:0] m_idx = '0;
    logic [31:0] m_data = '0;
    logic [31:0] exp_load = '0;
    logic [31:0] exp_rd = '0;
    logic [17:0] exp_last_addr = '0;
    logic [31:0] ref_mem [int];
    logic [31:0] m_off;
    logic        e_ready, e_we, e_oe, e_dqoe, e_hi;
    logic [17:0] e_addr;
    int          e_j;

    always @(negedge clk) begin
        if (chk_en) begin
            e_we = 1'b1; e_oe = 1'b1; e_dqoe = 1'b0; e_ready = 1'b0; e_addr = exp_last_addr;
            if (!busy) begin
                e_ready = !(mem_if.wr_en || mem_if.rd_en);
                chk("read_data_idle", mem_if.read_data, exp_rd);
            end else if (k == DONE_K) begin
                e_ready = 1'b1;
                if (!m_wr) exp_rd = exp_load;
                chk("read_data_done", mem_if.read_data, exp_rd);
            end else begin
                e_hi = (k > AC);
                e_j = e_hi ? k - AC - 1 : k - 1;
                e_addr = {m_idx, e_hi};
                exp_last_addr = e_addr;
                if (m_wr) begin
                    e_dqoe = 1'b1;
                    e_we = (e_j == AC - 1);
                    chk("dq_out", 32'(sram_dq_out), e_hi ? 32'(m_data[31:16]) : 32'(m_data[15:0]));
                    chk("read_data_hold", mem_if.read_data, exp_rd);
                end else begin
                    e_oe = 1'b0;
                end
            end
            chk("ready", 32'(mem_if.ready), 32'(e_ready));
            chk("we_n", 32'(sram_we_n), 32'(e_we));
            chk("oe_n", 32'(sram_oe_n), 32'(e_oe));
            chk("dq_oe", 32'(sram_dq_oe), 32'(e_dqoe));
            chk("sram_addr", 32'(sram_addr), 32'(e_addr));
        end
        // Advance to the next cycle using inputs as they will be sampled at the coming edge
        if (rst) begin
            busy = 0; exp_rd = '0; exp_last_addr = '0;
        end else if (busy) begin
            if (k == DONE_K) busy = 0;
            else k++;
        end else if (mem_if.wr_en || mem_if.rd_en) begin
            busy = 1; k = 1; m_wr = mem_if.wr_en;
            m_off = mem_if.address - BASE;
            m_idx = m_off[18:2];
            m_data = mem_if.write_data;
            if (m_wr) ref_mem[int'(m_idx)] = m_data;
            else exp_load = ref_mem.exists(int'(m_idx)) ? ref_mem[int'(m_idx)] : 32'h0;
        end
    end

    task automatic set_in(input bit w, input bit r, input logic [31:0] a, input logic [31:0] d);
        mem_if.wr_en = w; mem_if.rd_en = r; mem_if.address = a; mem_if.write_data = d;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            set_in(0, 0, 32'($urandom), 32'($urandom));
        end
    endtask

    // Issues a request, holds it until ready, returns at the falling edge of the DONE cycle.
    task automatic xact(input bit w, input bit r, input logic [31:0] a, input logic [31:0] d,
                        input int drop_k, output int lat, output logic [7:0] wem,
                        output logic [17:0] alo, output logic [17:0] ahi,
                        output logic [31:0] rdv, output int dcyc);
        @(posedge clk); #1;
        set_in(w, r, a, d);
        lat = -1; wem = '0; alo = '0; ahi = '0; rdv = '0; dcyc = 0;
        for (int kk = 0; kk < 40; kk++) begin
            @(negedge clk);
            if (!sram_we_n && kk < 8) wem[kk] = 1'b1;
            if (kk == 1) alo = sram_addr;
            if (kk == AC + 1) ahi = sram_addr;
            if (mem_if.ready) begin
                lat = kk; rdv = mem_if.read_data; dcyc = cyc;
                break;
            end
            if (kk + 1 == drop_k) begin
                @(posedge clk); #1;
                set_in(0, 0, 32'($urandom), 32'($urandom));
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    int          lat, d1, d2;
    logic [7:0]  wem;
    logic [17:0] alo, ahi;
    logic [31:0] rdv;

    initial begin
        for (int i = 0; i < 262144; i++) sram[i] = 16'h0;
        set_in(0, 0, 32'h0, 32'h0);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(mem_if.ready), 32'd1);
        chk("rst_read_data", mem_if.read_data, 32'h0);
        chk("rst_sram_addr", 32'(sram_addr), 32'h0);
        chk("rst_dq_out", 32'(sram_dq_out), 32'h0);
        chk("rst_strobes", {29'h0, sram_we_n, sram_oe_n, sram_dq_oe}, 32'b110);
        chk_en = 1;
        @(posedge clk); #1 rst = 1'b0;

        // Write 0xDEADBEEF at 1024
        xact(1, 0, 32'd1024, 32'hDEADBEEF, -1, lat, wem, alo, ahi, rdv, d1);
        chk("wr_latency", 32'(lat), 32'd5);
        chk("wr_we_mask", 32'(wem), 32'b0000_1010);
        idle(1);
        chk("sram_word0", 32'(sram[0]), 32'hBEEF);
        chk("sram_word1", 32'(sram[1]), 32'hDEAD);

        xact(0, 1, 32'd1024, 32'h0, -1, lat, wem, alo, ahi, rdv, d1);
        chk("rd_latency", 32'(lat), 32'd5);
        chk("rd_value", rdv, 32'hDEADBEEF);
        idle(1);

        xact(1, 0, 32'd1032, 32'h0BADF00D, -1, lat, wem, alo, ahi, rdv, d1);
        chk("map1032_lo", 32'(alo), 32'd4);
        chk("map1032_hi", 32'(ahi), 32'd5);
        chk("hold_through_write", rdv, 32'hDEADBEEF);
        idle(2);

        xact(0, 1, 32'd1027, 32'h0, -1, lat, wem, alo, ahi, rdv, d1);
        chk("align1027_lo", 32'(alo), 32'd0);
        chk("align1027_hi", 32'(ahi), 32'd1);
        chk("align1027_val", rdv, 32'hDEADBEEF);
        idle(1);

        xact(0, 1, 32'd1024 + 32'h80000, 32'h0, -1, lat, wem, alo, ahi, rdv, d1);
        chk("wrap_lo", 32'(alo), 32'd0);
        chk("wrap_val", rdv, 32'hDEADBEEF);
        idle(1);

        // Both enables, inputs dropped in cycle 2
        xact(1, 1, 32'd1028, 32'h12345678, 2, lat, wem, alo, ahi, rdv, d1);
        chk("both_latency", 32'(lat), 32'd5);
        chk("both_we_mask", 32'(wem), 32'b0000_1010);
        chk("both_read_data", rdv, 32'hDEADBEEF);
        idle(1);
        xact(0, 1, 32'd1028, 32'h0, -1, lat, wem, alo, ahi, rdv, d1);
        chk("both_readback", rdv, 32'h12345678);
        idle(1);

        // Reset during cycle 2 of a read
        @(posedge clk); #1 set_in(0, 1, 32'd1024, 32'h0);
        @(posedge clk); #1;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0; set_in(0, 0, 32'h0, 32'h0);
        @(negedge clk);
        chk("rstmid_read_data", mem_if.read_data, 32'h0);
        chk("rstmid_oe_n", 32'(sram_oe_n), 32'd1);
        chk("rstmid_ready", 32'(mem_if.ready), 32'd1);
        idle(1);

        // Back-to-back with requests held
        xact(1, 0, 32'd2048, 32'hA5A55A5A, -1, lat, wem, alo, ahi, rdv, d1);
        xact(0, 1, 32'd2048, 32'h0, -1, lat, wem, alo, ahi, rdv, d2);
        chk("b2b_spacing", 32'(d2 - d1), 32'd6);
        chk("b2b_value", rdv, 32'hA5A55A5A);
        idle(1);

        // Randomized traffic
        for (int i = 0; i < 150; i++) begin
            int          kind;
            int          drop;
            logic [31:0] a;
            kind = $urandom_range(0, 2);
            a = BASE + 32'($urandom_range(0, 15) << 2) + 32'($urandom_range(0, 3));
            if (i % 10 == 0) a = 32'($urandom);
            drop = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : -1;
            xact(kind != 0, kind != 1, a, 32'($urandom), drop, lat, wem, alo, ahi, rdv, d1);
            chk("rand_latency", 32'(lat), 32'(DONE_K));
            idle($urandom_range(0, 2));
        end
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
